dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the CPU's data bus. It is the slave end of the memory stage's load/store path: it accepts one request at a time from the memory stage, then after a fixed latency returns a response carrying the read data, or the commit of a write. It is backed by a word-addressed SRAM array. It serves as the simulation and FPGA data memory, and as the reference slave for verifying the memory stage's handshake.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 64-bit words; power of two, ≥2.
- LATENCY, 2: cycles from accept to data_ok; legal range 1–15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; requester holds all req_* stable until data_ok.
- req_addr  in  64  byte address.
- req_size  in  3  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B; values 4–7 are illegal.
- req_strobe  in  8  byte-lane write enables; all zeros means a read.
- req_data  in  64  write data, lane-aligned, so byte i is bits [8i+7:8i].
- resp_addr_ok  out  1  request accepted this cycle.
- resp_data_ok  out  1  response valid this cycle; single-cycle pulse.
- resp_data  out  64  full aligned word read; valid only while data_ok is high.
- resp_err  out  1  misaligned or illegal-size access; valid only while data_ok is high.

## Operation
- Index = req_addr[3 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×8.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: resp_addr_ok = req_valid. If req_valid is high:
    - latch addr, size, strobe and data;
    - load cnt = LATENCY−1;
    - go to RESP if LATENCY = 1, otherwise go to WAIT.
  - WAIT: decrement cnt. Go to RESP when the decrement reaches 0.
  - RESP: resp_data_ok = 1, then return to IDLE. A new request cannot be accepted in this cycle.
- Error check is done on the latched request:
  - size > 3 is an error;
  - an address not aligned to 2^size bytes is an error.
- Read (strobe = 0): resp_data = mem[index]. This is the whole word, not shifted; the requester extracts the bytes it needs.
- Write (strobe ≠ 0, no error): on the rising edge that ends RESP, mem[index] byte i ← data byte i for each i where strobe[i] = 1. Other bytes are unchanged.
  - resp_data during a write RESP returns the pre-write word.
- Error: no write occurs, resp_data = 0, resp_err = 1.
- The strobe is applied exactly as given. It is not cross-checked against size.
- If req_valid falls while in WAIT or RESP, the latched transaction still completes and data_ok still pulses.
- Memory array contents are not affected by reset and are undefined at power-up.

## Timing
- Reset value of every output is 0. FSM resets to IDLE and cnt resets to 0.
- Reset asserted mid-transaction aborts it: no write occurs, no data_ok is issued, and the FSM returns to IDLE asynchronously.
- Accept happens in cycle t, when addr_ok = 1 combinationally from req_valid in IDLE. data_ok = 1 in cycle t+LATENCY.
- Earliest next accept is cycle t+LATENCY+1. Peak throughput is one access per LATENCY+1 cycles.
- A request held high across RESP is treated as a new request in the following IDLE cycle. The requester must change or drop req_valid in the cycle after data_ok to avoid a duplicate access.
- resp_addr_ok and resp_data_ok are never high in the same cycle.
- resp_data, resp_err and resp_data_ok are registered or derived from state only; they have no combinational path from req_*.

## Test plan
- Reset/idle: hold reset low for 3 cycles with req_valid = 1 → all outputs stay 0 and there is no accept. Release reset → addr_ok = 1 in the first cycle.
- Word round trip (LATENCY = 2):
  - write addr 0x10, size 3, strobe 0xFF, data 0x1122334455667788 → addr_ok at t, data_ok at t+2, resp_err = 0;
  - read addr 0x10 → resp_data = 0x1122334455667788.
- Byte strobe: write addr 0x13, size 0, strobe 0x08, data 0x00000000AA000000 into the word above → read of 0x10 returns 0x11223344AA667788.
- Misaligned: write addr 0x12, size 2 (4 B), strobe 0x0F → data_ok with resp_err = 1 and resp_data = 0. A subsequent read of 0x10 is unchanged.
- Wrap and latency:
  - with DEPTH_WORDS = 256, write addr 0x808 → a read of 0x8 returns the same data;
  - with LATENCY = 1, data_ok arrives exactly one cycle after addr_ok, and back-to-back held requests are accepted every 2 cycles.
- Reset mid-op: assert reset during WAIT of a write to 0x20 → no data_ok, and a later read of 0x20 shows the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with fixed latency,
// backed by a 64-bit word-addressed array.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LANES  = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2:0]         lo_q, lo_d;
    logic [2:0]         size_q, size_d;
    logic [7:0]         strobe_q, strobe_d;
    logic [63:0]        wdata_q, wdata_d;

    logic               resp_data_ok_q;
    logic               resp_err_q;
    logic [63:0]        resp_data_q;

    logic               err_d;
    logic               err_q;
    logic               wr_en_c;

    logic [63:0]        mem_q [DEPTH_WORDS];

    // Address bits above the word index only select aliases of the same word.
    logic unused_addr_hi_c;
    assign unused_addr_hi_c = ^req_addr[63:3+IDX_W];

    // Illegal size, or address not aligned to the access size.
    function automatic logic bad_access(input logic [2:0] size, input logic [2:0] lo);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = lo[0];
            3'd2:    bad = |lo[1:0];
            3'd3:    bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // FSM state and latched request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state, request capture and accept strobe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lo_d         = lo_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        resp_addr_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so nothing is accepted while reset is held.
                resp_addr_ok = req_valid & reset;
                if (req_valid) begin
                    idx_d    = req_addr[3 +: IDX_W];
                    lo_d     = req_addr[2:0];
                    size_d   = req_size;
                    strobe_d = req_strobe;
                    wdata_d  = req_data;
                    cnt_d    = CNT_LOAD;
                    state_d  = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err_d   = bad_access(size_d, lo_d);
    assign err_q   = bad_access(size_q, lo_q);
    assign wr_en_c = (state_q == S_RESP) && (|strobe_q) && !err_q;

    // Response registers are loaded on the edge entering RESP; the array is
    // not written until RESP ends, so the read returns the pre-write word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data_ok_q <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_data_q    <= '0;
        end else begin
            resp_data_ok_q <= (state_d == S_RESP);
            resp_err_q     <= (state_d == S_RESP) && err_d;
            resp_data_q    <= ((state_d == S_RESP) && !err_d) ? mem_q[idx_d] : '0;
        end
    end

    // Byte-lane write on the edge that ends RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (strobe_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign resp_data_ok = resp_data_ok_q;
    assign resp_err     = resp_err_q;
    assign resp_data    = resp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance A (LATENCY 2, 256 words) and
// instance B (LATENCY 1, 16 words) share a clock but have separate resets.
module tb_dmem_responder;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        chk_data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A signals
    logic        rst_a, a_valid;
    logic [63:0] a_addr, a_wdata;
    logic [2:0]  a_size;
    logic [7:0]  a_strb;
    logic        a_addr_ok, a_data_ok, a_err;
    logic [63:0] a_rdata;

    // Instance B signals
    logic        rst_b, b_valid;
    logic [63:0] b_addr, b_wdata;
    logic [2:0]  b_size;
    logic [7:0]  b_strb;
    logic        b_addr_ok, b_data_ok, b_err;
    logic [63:0] b_rdata;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
        .clk          (clk),
        .reset        (rst_a),
        .req_valid    (a_valid),
        .req_addr     (a_addr),
        .req_size     (a_size),
        .req_strobe   (a_strb),
        .req_data     (a_wdata),
        .resp_addr_ok (a_addr_ok),
        .resp_data_ok (a_data_ok),
        .resp_data    (a_rdata),
        .resp_err     (a_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_b (
        .clk          (clk),
        .reset        (rst_b),
        .req_valid    (b_valid),
        .req_addr     (b_addr),
        .req_size     (b_size),
        .req_strobe   (b_strb),
        .req_data     (b_wdata),
        .resp_addr_ok (b_addr_ok),
        .resp_data_ok (b_data_ok),
        .resp_data    (b_rdata),
        .resp_err     (b_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor A: pop and compare on every data_ok.
    always @(negedge clk) begin
        if (a_data_ok) begin
            check("a_addr_ok_with_data_ok", 64'(a_addr_ok), 64'd0);
            if (qa.size() == 0) begin
                check("a_unexpected_data_ok", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_latency", 64'(cyc), 64'(e.due));
                check("a_err", 64'(a_err), 64'(e.err));
                if (e.chk_data) check("a_data", a_rdata, e.data);
            end
        end
    end

    // Monitor B: pop and compare on every data_ok.
    always @(negedge clk) begin
        if (b_data_ok) begin
            check("b_addr_ok_with_data_ok", 64'(b_addr_ok), 64'd0);
            if (qb.size() == 0) begin
                check("b_unexpected_data_ok", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_latency", 64'(cyc), 64'(e.due));
                check("b_err", 64'(b_err), 64'(e.err));
                if (e.chk_data) check("b_data", b_rdata, e.data);
            end
        end
    end

    task automatic set_req(input bit sel, input bit v, input logic [63:0] addr,
                           input logic [2:0] size, input logic [7:0] strb,
                           input logic [63:0] wdata);
        if (!sel) begin
            a_valid = v; a_addr = addr; a_size = size; a_strb = strb; a_wdata = wdata;
        end else begin
            b_valid = v; b_addr = addr; b_size = size; b_strb = strb; b_wdata = wdata;
        end
    endtask

    task automatic push_exp(input bit sel, input logic [63:0] data, input bit err,
                            input bit chk, input int due);
        exp_t e;
        e.data = data; e.err = err; e.chk_data = chk; e.due = due;
        if (!sel) qa.push_back(e);
        else      qb.push_back(e);
    endtask

    task automatic drain(input bit sel);
        int left;
        left = 1;
        for (int i = 0; i < 40 && left != 0; i++) begin
            @(posedge clk);
            left = sel ? qb.size() : qa.size();
        end
        check(sel ? "b_drain" : "a_drain", 64'(left), 64'd0);
    endtask

    // One request: present, wait for accept, queue expectation, drop, drain.
    task automatic do_req(input bit sel, input logic [63:0] addr, input logic [2:0] size,
                          input logic [7:0] strb, input logic [63:0] wdata,
                          input logic [63:0] edata, input bit eerr, input bit echk);
        bit got;
        @(posedge clk); #1;
        set_req(sel, 1'b1, addr, size, strb, wdata);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((sel ? b_addr_ok : a_addr_ok) == 1'b1) got = 1'b1;
        end
        check(sel ? "b_accept" : "a_accept", 64'(got), 64'd1);
        if (got) push_exp(sel, edata, eerr, echk, cyc + (sel ? 1 : 2));
        @(posedge clk); #1;
        set_req(sel, 1'b0, '0, '0, '0, '0);
        drain(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_acc;
        int n_acc;

        rst_a = 1'b0;
        rst_b = 1'b0;
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
        // Request held during reset: must not be accepted.
        set_req(1'b0, 1'b1, 64'h40, 3'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D);

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {a_addr_ok, a_data_ok, a_err, a_rdata[60:0]}, 64'd0);
        end
        check("reset_data_hi", 64'(a_rdata[63:61]), 64'd0);

        @(posedge clk); #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("first_accept_after_reset", 64'(a_addr_ok), 64'd1);
        if (a_addr_ok) push_exp(1'b0, '0, 1'b0, 1'b0, cyc + 2);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        drain(1'b0);

        // Word round trip
        do_req(1'b0, 64'h10, 3'd3, 8'hFF, 64'h11223344_55667788, '0, 1'b0, 1'b0);
        do_req(1'b0, 64'h10, 3'd3, 8'h00, '0, 64'h11223344_55667788, 1'b0, 1'b1);
        // Byte strobe: write returns the pre-write word
        do_req(1'b0, 64'h13, 3'd0, 8'h08, 64'h00000000_AA000000,
               64'h11223344_55667788, 1'b0, 1'b1);
        do_req(1'b0, 64'h10, 3'd3, 8'h00, '0, 64'h11223344_AA667788, 1'b0, 1'b1);
        // Misaligned write: error, zero data, no write
        do_req(1'b0, 64'h12, 3'd2, 8'h0F, 64'hFFFFFFFF_FFFFFFFF, '0, 1'b1, 1'b1);
        do_req(1'b0, 64'h10, 3'd3, 8'h00, '0, 64'h11223344_AA667788, 1'b0, 1'b1);
        // Illegal size
        do_req(1'b0, 64'h10, 3'd5, 8'h00, '0, '0, 1'b1, 1'b1);
        // Aligned halfword read of an odd-halfword address is legal
        do_req(1'b0, 64'h16, 3'd1, 8'h00, '0, 64'h11223344_AA667788, 1'b0, 1'b1);
        // Address wrap at 256 words
        do_req(1'b0, 64'h808, 3'd3, 8'hFF, 64'h01234567_89ABCDEF, '0, 1'b0, 1'b0);
        do_req(1'b0, 64'h8, 3'd3, 8'h00, '0, 64'h01234567_89ABCDEF, 1'b0, 1'b1);
        // Write made during the reset-release cycle
        do_req(1'b0, 64'h40, 3'd3, 8'h00, '0, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1);
        // Prior contents of 0x20
        do_req(1'b0, 64'h20, 3'd3, 8'hFF, 64'hA5A5A5A5_A5A5A5A5, '0, 1'b0, 1'b0);

        // Reset during WAIT of a write to 0x20 aborts it
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 64'h20, 3'd3, 8'hFF, 64'h5A5A5A5A_5A5A5A5A);
        @(negedge clk);
        check("abort_accept", 64'(a_addr_ok), 64'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_data_ok", 64'(a_data_ok), 64'd0);
        end
        @(posedge clk); #1;
        rst_a = 1'b1;
        do_req(1'b0, 64'h20, 3'd3, 8'h00, '0, 64'hA5A5A5A5_A5A5A5A5, 1'b0, 1'b1);

        // Instance B: LATENCY 1, 16 words (wrap at 0x80)
        do_req(1'b1, 64'h18, 3'd3, 8'hFF, 64'hFEDCBA98_76543210, '0, 1'b0, 1'b0);
        do_req(1'b1, 64'h98, 3'd3, 8'h00, '0, 64'hFEDCBA98_76543210, 1'b0, 1'b1);

        // Held request: accepted every second cycle
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 64'h18, 3'd3, 8'h00, '0);
        last_acc = -1;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b_addr_ok) begin
                if (last_acc >= 0) check("b_accept_spacing", 64'(cyc - last_acc), 64'd2);
                last_acc = cyc;
                n_acc++;
                push_exp(1'b1, 64'hFEDCBA98_76543210, 1'b0, 1'b1, cyc + 1);
            end
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
        check("b_accept_count", 64'(n_acc), 64'd4);
        drain(1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
